// File: rtl/bcd_display_ctrl.sv
// Three-digit seven-segment controller: binary-to-BCD conversion by iterative
// double-dabble (one bit per clock) plus a prescaled, time-multiplexed digit scan.
module bcd_display_ctrl #(
    parameter int SCAN_DIV      = 50000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] value,
    output logic       busy,
    output logic       done,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic [2:0] an,
    output logic [6:0] seg
);

    localparam int PW = $clog2(SCAN_DIV);

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        UPDATE
    } state_t;

    state_t      state_reg, state_next;
    logic [7:0]  shift_reg, shift_next;
    logic [2:0]  cnt_reg, cnt_next;
    logic [11:0] bcd_reg, bcd_next;
    logic [11:0] bcd_adj;
    logic [3:0]  hundreds_reg, tens_reg, ones_reg;
    logic        done_reg;
    logic [PW-1:0] presc_reg;
    logic [1:0]  scan_idx_reg;

    // Add-3 correction on every scratch nibble before the shift.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_add3
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5)
                                        ? bcd_reg[gi*4 +: 4] + 4'd3
                                        : bcd_reg[gi*4 +: 4];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        shift_next = shift_reg;
        cnt_next   = cnt_reg;
        bcd_next   = bcd_reg;
        case (state_reg)
            IDLE: begin
                if (load) begin
                    shift_next = value;
                    bcd_next   = 12'd0;
                    cnt_next   = 3'd7;
                    state_next = CONVERT;
                end
            end
            CONVERT: begin
                bcd_next = (bcd_adj << 1) | {11'd0, shift_reg[cnt_reg]};
                if (cnt_reg == 3'd0) begin
                    state_next = UPDATE;
                end else begin
                    cnt_next = cnt_reg - 3'd1;
                end
            end
            UPDATE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            shift_reg    <= 8'd0;
            cnt_reg      <= 3'd0;
            bcd_reg      <= 12'd0;
            hundreds_reg <= 4'd0;
            tens_reg     <= 4'd0;
            ones_reg     <= 4'd0;
            done_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            shift_reg <= shift_next;
            cnt_reg   <= cnt_next;
            bcd_reg   <= bcd_next;
            done_reg  <= (state_reg == UPDATE);
            if (state_reg == UPDATE) begin
                hundreds_reg <= bcd_reg[11:8];
                tens_reg     <= bcd_reg[7:4];
                ones_reg     <= bcd_reg[3:0];
            end
        end
    end

    // Scan timing runs free of the FSM so a commit never disturbs the hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_reg    <= '0;
            scan_idx_reg <= 2'd0;
        end else if (presc_reg == PW'(SCAN_DIV - 1)) begin
            presc_reg    <= '0;
            scan_idx_reg <= (scan_idx_reg == 2'd2) ? 2'd0 : scan_idx_reg + 2'd1;
        end else begin
            presc_reg <= presc_reg + 1'b1;
        end
    end

    generate
        for (gi = 0; gi < 3; gi++) begin : g_an
            assign an[gi] = (scan_idx_reg != 2'(gi));
        end
    endgenerate

    logic [3:0] digit_sel;
    logic       blank;

    always_comb begin
        digit_sel = ones_reg;
        blank     = 1'b0;
        case (scan_idx_reg)
            2'd1: begin
                digit_sel = tens_reg;
                blank     = BLANK_LEADING && (hundreds_reg == 4'd0) && (tens_reg == 4'd0);
            end
            2'd2: begin
                digit_sel = hundreds_reg;
                blank     = BLANK_LEADING && (hundreds_reg == 4'd0);
            end
            default: begin
                digit_sel = ones_reg;
                blank     = 1'b0;
            end
        endcase
    end

    // Active-low segment decode, order {g,f,e,d,c,b,a}.
    always_comb begin
        seg = 7'h7F;
        if (!blank) begin
            case (digit_sel)
                4'd0:    seg = 7'h40;
                4'd1:    seg = 7'h79;
                4'd2:    seg = 7'h24;
                4'd3:    seg = 7'h30;
                4'd4:    seg = 7'h19;
                4'd5:    seg = 7'h12;
                4'd6:    seg = 7'h02;
                4'd7:    seg = 7'h78;
                4'd8:    seg = 7'h00;
                4'd9:    seg = 7'h10;
                default: seg = 7'h7F;
            endcase
        end
    end

    assign busy     = (state_reg != IDLE);
    assign done     = done_reg;
    assign hundreds = hundreds_reg;
    assign tens     = tens_reg;
    assign ones     = ones_reg;

endmodule
